oka_split_subproduct_seq: RTL and testbench

Sequential front end of the overlap-free Karatsuba (OKA) GF(2) polynomial multiplier. It accepts two N-bit binary polynomials and splits each into even-index and odd-index coefficient halves. It computes the four H x H carry-less sub-products on one shared shift-and-XOR datapath. It presents them as the p1..p4 bundle consumed by the overlap recombination stage: even-position term p1, odd-position terms p2 and p3, shifted even-position term p4.

---
 rtl/oka_split_subproduct_seq_if.sv | 29 ++
 rtl/oka_split_subproduct_seq.sv | 178 +++++++++++++++++
 tb/tb_oka_split_subproduct_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oka_split_subproduct_seq_if.sv
// Operand/result bundle for the OKA split sub-product engine.
// The slave modport is the engine side; the master modport is the producer/consumer side.
interface oka_split_subproduct_seq_if #(
   parameter int unsigned N = 10
);
   localparam int unsigned H = N / 2;

   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*H-2:0] p1;
   logic [2*H-2:0] p2;
   logic [2*H-2:0] p3;
   logic [2*H-2:0] p4;
   logic           busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p1, p2, p3, p4, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p1, p2, p3, p4, busy
   );
endinterface

// File: rtl/oka_split_subproduct_seq.sv
// Sequential OKA front end: splits operands into even/odd halves and forms the H x H carry-less
// sub-products on one shift-and-XOR datapath. Define KARATSUBA_MID_EN for the 3-product schedule.
module oka_split_subproduct_seq #(
   parameter int unsigned N = 10
) (
   input logic                      clk,
   input logic                      rst,
   oka_split_subproduct_seq_if.slave bus
);
   localparam int unsigned H    = N / 2;
   localparam int unsigned W    = 2 * H - 1;
   localparam int unsigned BitW = (H > 1) ? $clog2(H) : 1;
`ifdef KARATSUBA_MID_EN
   localparam int unsigned NumProd = 3;
`else
   localparam int unsigned NumProd = 4;
`endif

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e          state_q, state_d;
   logic [H-1:0]    ae_q, ae_d, ao_q, ao_d, be_q, be_d, bo_q, bo_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [BitW-1:0] bit_idx_q, bit_idx_d;
   logic [1:0]      prod_idx_q, prod_idx_d;
   logic [W-1:0]    p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;

   logic [H-1:0]    a_even, a_odd, b_even, b_odd;
   logic [H-1:0]    mcand, mplier;
   logic [W-1:0]    partial, acc_x;

   always_comb begin
      a_even = '0;
      a_odd  = '0;
      b_even = '0;
      b_odd  = '0;
      for (int unsigned i = 0; i < H; i++) begin
         a_even[i] = bus.a[2*i];
         a_odd[i]  = bus.a[2*i+1];
         b_even[i] = bus.b[2*i];
         b_odd[i]  = bus.b[2*i+1];
      end
   end

   // Operand pair for the product currently being accumulated.
   always_comb begin
      mcand  = ae_q;
      mplier = be_q;
`ifdef KARATSUBA_MID_EN
      unique case (prod_idx_q)
         2'd1: begin
            mcand  = ao_q;
            mplier = bo_q;
         end
         2'd2: begin
            mcand  = ae_q ^ ao_q;
            mplier = be_q ^ bo_q;
         end
         default: ;
      endcase
`else
      unique case (prod_idx_q)
         2'd1: mplier = bo_q;
         2'd2: mcand = ao_q;
         2'd3: begin
            mcand  = ao_q;
            mplier = bo_q;
         end
         default: ;
      endcase
`endif
      partial = mplier[bit_idx_q] ? (W'(mcand) << bit_idx_q) : '0;
      acc_x   = acc_q ^ partial;
   end

   always_comb begin
      state_d    = state_q;
      ae_d       = ae_q;
      ao_d       = ao_q;
      be_d       = be_q;
      bo_d       = bo_q;
      acc_d      = acc_q;
      bit_idx_d  = bit_idx_q;
      prod_idx_d = prod_idx_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      p3_d       = p3_q;
      p4_d       = p4_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               ae_d       = a_even;
               ao_d       = a_odd;
               be_d       = b_even;
               bo_d       = b_odd;
               acc_d      = '0;
               bit_idx_d  = '0;
               prod_idx_d = '0;
               state_d    = StMul;
            end
         end
         StMul: begin
            if (bit_idx_q == BitW'(H - 1)) begin
               acc_d      = '0;
               bit_idx_d  = '0;
               prod_idx_d = prod_idx_q + 2'd1;
`ifdef KARATSUBA_MID_EN
               // Middle term folds out p1 and p4 so p2^p3 matches the 4-product build.
               unique case (prod_idx_q)
                  2'd0: p1_d = acc_x;
                  2'd1: p4_d = acc_x;
                  default: begin
                     p2_d = acc_x ^ p1_q ^ p4_q;
                     p3_d = '0;
                  end
               endcase
`else
               unique case (prod_idx_q)
                  2'd0: p1_d = acc_x;
                  2'd1: p2_d = acc_x;
                  2'd2: p3_d = acc_x;
                  default: p4_d = acc_x;
               endcase
`endif
               if (prod_idx_q == 2'(NumProd - 1)) begin
                  prod_idx_d = '0;
                  state_d    = StDone;
               end
            end else begin
               acc_d     = acc_x;
               bit_idx_d = bit_idx_q + BitW'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ae_q       <= '0;
         ao_q       <= '0;
         be_q       <= '0;
         bo_q       <= '0;
         acc_q      <= '0;
         bit_idx_q  <= '0;
         prod_idx_q <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         p3_q       <= '0;
         p4_q       <= '0;
      end else begin
         state_q    <= state_d;
         ae_q       <= ae_d;
         ao_q       <= ao_d;
         be_q       <= be_d;
         bo_q       <= bo_d;
         acc_q      <= acc_d;
         bit_idx_q  <= bit_idx_d;
         prod_idx_q <= prod_idx_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         p3_q       <= p3_d;
         p4_q       <= p4_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.busy      = (state_q == StMul);
   assign bus.out_valid = (state_q == StDone);
   assign bus.p1        = p1_q;
   assign bus.p2        = p2_q;
   assign bus.p3        = p3_q;
   assign bus.p4        = p4_q;
endmodule

// File: tb/tb_oka_split_subproduct_seq.sv
// Self-checking bench for oka_split_subproduct_seq: a transaction-level model checked every cycle,
// plus directed vectors with hand-computed sub-products. Honours KARATSUBA_MID_EN.
module tb_oka_split_subproduct_seq;
   localparam int unsigned N = 10;
   localparam int unsigned H = 5;
`ifdef KARATSUBA_MID_EN
   localparam int unsigned NP = 3;
`else
   localparam int unsigned NP = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   started = 1'b0;

   oka_split_subproduct_seq_if #(.N(N)) bus ();

   oka_split_subproduct_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [8:0] clmul_h(input logic [4:0] x, input logic [4:0] y);
      logic [8:0] r = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            if (x[i] && y[j]) r[i+j] = ~r[i+j];
      return r;
   endfunction

   function automatic logic [18:0] clmul_n(input logic [9:0] x, input logic [9:0] y);
      logic [18:0] r = '0;
      for (int i = 0; i < 10; i++)
         for (int j = 0; j < 10; j++)
            if (x[i] && y[j]) r[i+j] = ~r[i+j];
      return r;
   endfunction

   function automatic logic [18:0] spread(input logic [8:0] v);
      logic [18:0] r = '0;
      for (int i = 0; i < 9; i++) r[2*i] = v[i];
      return r;
   endfunction

   task automatic model_products(input logic [9:0] a, input logic [9:0] b,
                                 output logic [8:0] q1, output logic [8:0] q2,
                                 output logic [8:0] q3, output logic [8:0] q4);
      logic [4:0] ae, ao, be, bo;
      for (int i = 0; i < 5; i++) begin
         ae[i] = a[2*i];
         ao[i] = a[2*i+1];
         be[i] = b[2*i];
         bo[i] = b[2*i+1];
      end
      q1 = clmul_h(ae, be);
      q4 = clmul_h(ao, bo);
`ifdef KARATSUBA_MID_EN
      q2 = clmul_h(ae ^ ao, be ^ bo) ^ q1 ^ q4;
      q3 = '0;
`else
      q2 = clmul_h(ae, bo);
      q3 = clmul_h(ao, be);
`endif
   endtask

   // Transaction model: 0 idle, 1 computing, 2 result held.
   int         m_phase = 0;
   int         m_cnt = 0;
   logic [8:0] mp1 = '0, mp2 = '0, mp3 = '0, mp4 = '0;
   logic [8:0] np1, np2, np3, np4;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
         mp1 = '0; mp2 = '0; mp3 = '0; mp4 = '0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
               m_phase = 1;
               m_cnt   = 0;
               model_products(bus.a, bus.b, np1, np2, np3, np4);
            end
            1: begin
               m_cnt++;
               if (m_cnt == NP * H) begin
                  m_phase = 2;
                  mp1 = np1; mp2 = np2; mp3 = np3; mp4 = np4;
               end
            end
            default: if (bus.out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
         chk("busy", 32'(bus.busy), 32'(m_phase == 1));
         chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
         if (m_phase != 1) begin
            chk("p1_model", 32'(bus.p1), 32'(mp1));
            chk("p2_model", 32'(bus.p2), 32'(mp2));
            chk("p3_model", 32'(bus.p3), 32'(mp3));
            chk("p4_model", 32'(bus.p4), 32'(mp4));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [9:0] a, input logic [9:0] b);
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      tick();
      bus.in_valid = 1'b0;
      bus.a = 10'($urandom);
      bus.b = 10'($urandom);
   endtask

   task automatic wait_done();
      int lat = 0;
      while (!bus.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(NP * H));
   endtask

   task automatic check_lit(input logic [8:0] e1, input logic [8:0] e2, input logic [8:0] e3,
                            input logic [8:0] e4, input logic [9:0] a, input logic [9:0] b);
      chk("p1_lit", 32'(bus.p1), 32'(e1));
      chk("p2_lit", 32'(bus.p2), 32'(e2));
      chk("p3_lit", 32'(bus.p3), 32'(e3));
      chk("p4_lit", 32'(bus.p4), 32'(e4));
      chk("recombine", 32'(spread(bus.p1) ^ (spread(bus.p2 ^ bus.p3) << 1) ^ (spread(bus.p4) << 2)),
          32'(clmul_n(a, b)));
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("idle_after_release", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] ra, rb;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      tick();
      tick();
      started = 1'b1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_p1", 32'(bus.p1), 32'd0);
      chk("rst_p4", 32'(bus.p4), 32'd0);
      rst = 1'b0;
      tick();

      start_op(10'h001, 10'h001);
      wait_done();
      check_lit(9'h001, 9'h000, 9'h000, 9'h000, 10'h001, 10'h001);
      release_out();

      start_op(10'h003, 10'h002);
      wait_done();
      check_lit(9'h000, 9'h001, 9'h000, 9'h001, 10'h003, 10'h002);
      release_out();

      start_op(10'h3FF, 10'h3FF);
      wait_done();
`ifdef KARATSUBA_MID_EN
      check_lit(9'h155, 9'h000, 9'h000, 9'h155, 10'h3FF, 10'h3FF);
`else
      check_lit(9'h155, 9'h155, 9'h155, 9'h155, 10'h3FF, 10'h3FF);
`endif
      // Backpressure with a stray operand pulse that must be ignored.
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = (i == 3);
         bus.a = 10'h155;
         bus.b = 10'h0AA;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_p1_hold", 32'(bus.p1), 32'h155);
      chk("bp_p4_hold", 32'(bus.p4), 32'h155);
      // Release while offering a new operand: no acceptance on the same edge.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a = 10'h002;
      bus.b = 10'h002;
      tick();
      bus.out_ready = 1'b0;
      chk("turn_in_ready", 32'(bus.in_ready), 32'd1);
      chk("turn_busy", 32'(bus.busy), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("turn_accept", 32'(bus.busy), 32'd1);
      wait_done();
      check_lit(9'h000, 9'h000, 9'h000, 9'h001, 10'h002, 10'h002);
      release_out();

      // Reset during MUL cycle 7.
      start_op(10'h2A5, 10'h1C3);
      repeat (6) tick();
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_p1", 32'(bus.p1), 32'd0);
      chk("mid_rst_p2", 32'(bus.p2), 32'd0);
      chk("mid_rst_p3", 32'(bus.p3), 32'd0);
      chk("mid_rst_p4", 32'(bus.p4), 32'd0);
      start_op(10'h2A5, 10'h1C3);
      wait_done();
      model_products(10'h2A5, 10'h1C3, np1, np2, np3, np4);
      check_lit(np1, np2, np3, np4, 10'h2A5, 10'h1C3);
      release_out();

      for (int k = 0; k < 4; k++) begin
         logic [8:0] q1, q2, q3, q4;
         ra = 10'($urandom);
         rb = 10'($urandom);
         start_op(ra, rb);
         wait_done();
         model_products(ra, rb, q1, q2, q3, q4);
         check_lit(q1, q2, q3, q4, ra, rb);
         release_out();
      end

      tick();
      started = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
